checkpoint_manager: RTL and testbench

- Allocates, tracks and frees branch checkpoint IDs in program order.
- Sits upstream of the recovery FSM: rename asks it for a checkpoint ID per branch, and that ID travels with the branch to the recovery FSM.
- Consumes the recovery FSM's flush, rat_restore and recovery_in_progress outputs so it can free checkpoints belonging to squashed instructions.
- Internally a circular ring of CHECKPOINT_COUNT slots, each holding the owning branch's ROB index.

---
 rtl/ckpt_pkg.sv | 20 ++
 rtl/checkpoint_manager_if.sv | 42 ++++
 rtl/ckpt_truncate_finder.sv | 27 ++
 rtl/checkpoint_manager.sv | 117 +++++++++++
 tb/tb_checkpoint_manager.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/ckpt_pkg.sv
// rtl/ckpt_pkg.sv - checkpoint manager sizing, slot record and ROB age helper
package ckpt_pkg;
  localparam int CHECKPOINT_COUNT = 8;
  localparam int CKPT_ID_W        = $clog2(CHECKPOINT_COUNT);
  localparam int ROB_IDX_W        = 7;

  typedef logic [CKPT_ID_W-1:0] ckpt_id_t;
  typedef logic [CKPT_ID_W:0]   ckpt_cnt_t;
  typedef logic [ROB_IDX_W-1:0] rob_idx_t;

  typedef struct packed {
    logic     valid;
    rob_idx_t rob_idx;
  } ckpt_slot_t;

  // Distance from the oldest ROB entry, modulo the ROB index space
  function automatic rob_idx_t age(input rob_idx_t x, input rob_idx_t rob_head);
    return x - rob_head;
  endfunction
endpackage

// File: rtl/checkpoint_manager_if.sv
// rtl/checkpoint_manager_if.sv - rename/recovery bus of the checkpoint manager; CKPT_STATS_EN adds stall_cycles
interface checkpoint_manager_if;
  import ckpt_pkg::*;

  logic      alloc_req;
  rob_idx_t  alloc_rob_idx;
  logic      alloc_ready;
  logic      alloc_grant;
  ckpt_id_t  alloc_id;
  logic      release_valid;
  ckpt_id_t  release_id;
  rob_idx_t  rob_head;
  logic      flush;
  rob_idx_t  flush_rob_idx;
  logic      rat_restore;
  ckpt_id_t  rat_restore_checkpoint;
  logic      recovery_in_progress;
  ckpt_cnt_t live_count;
  logic      empty;
  logic      release_error;
`ifdef CKPT_STATS_EN
  logic [31:0] stall_cycles;
`endif

  modport master (
    output alloc_req, alloc_rob_idx, release_valid, release_id, rob_head,
           flush, flush_rob_idx, rat_restore, rat_restore_checkpoint, recovery_in_progress,
    input  alloc_ready, alloc_grant, alloc_id, live_count, empty, release_error
`ifdef CKPT_STATS_EN
         , stall_cycles
`endif
  );

  modport slave (
    input  alloc_req, alloc_rob_idx, release_valid, release_id, rob_head,
           flush, flush_rob_idx, rat_restore, rat_restore_checkpoint, recovery_in_progress,
    output alloc_ready, alloc_grant, alloc_id, live_count, empty, release_error
`ifdef CKPT_STATS_EN
         , stall_cycles
`endif
  );
endinterface

// File: rtl/ckpt_truncate_finder.sv
// rtl/ckpt_truncate_finder.sv - finds the oldest live slot, scanning from head, at or younger than a boundary
module ckpt_truncate_finder
  import ckpt_pkg::*;
(
  input  ckpt_slot_t slots_i [CHECKPOINT_COUNT],
  input  ckpt_id_t   head_i,
  input  rob_idx_t   rob_head_i,
  input  rob_idx_t   boundary_i,
  output logic       found_o,
  output ckpt_id_t   slot_o
);
  ckpt_id_t idx;

  always_comb begin
    found_o = 1'b0;
    slot_o  = head_i;
    idx     = head_i;
    for (int i = 0; i < CHECKPOINT_COUNT; i++) begin
      idx = head_i + ckpt_id_t'(i);
      if (!found_o && slots_i[idx].valid &&
          age(slots_i[idx].rob_idx, rob_head_i) >= age(boundary_i, rob_head_i)) begin
        found_o = 1'b1;
        slot_o  = idx;
      end
    end
  end
endmodule

// File: rtl/checkpoint_manager.sv
// rtl/checkpoint_manager.sv - program-order ring of branch checkpoints with release, flush and restore truncation
// Optional stall counter under CKPT_STATS_EN.
module checkpoint_manager
  import ckpt_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  checkpoint_manager_if.slave  cm
);
  localparam ckpt_cnt_t FULL_CNT = ckpt_cnt_t'(CHECKPOINT_COUNT);

  ckpt_id_t   head_q, head_d, tail_q, tail_d;
  ckpt_cnt_t  count_q, count_d;
  ckpt_slot_t slots_q [CHECKPOINT_COUNT];
  ckpt_slot_t slots_d [CHECKPOINT_COUNT];
  logic       err_q, err_d;
`ifdef CKPT_STATS_EN
  logic [31:0] stall_q, stall_d;
`endif

  logic     alloc_ready, grant, rel_ok, flush_found, restore_ok, trunc;
  ckpt_id_t flush_slot, flush_off, restore_off, trunc_off;

  ckpt_truncate_finder u_flush_finder (
    .slots_i    (slots_q),
    .head_i     (head_q),
    .rob_head_i (cm.rob_head),
    .boundary_i (cm.flush_rob_idx),
    .found_o    (flush_found),
    .slot_o     (flush_slot)
  );

  always_comb begin
    alloc_ready = (count_q < FULL_CNT) && !cm.flush && !cm.recovery_in_progress && !cm.rat_restore;
    grant       = cm.alloc_req && alloc_ready;
    rel_ok      = cm.release_valid && (count_q != '0) && (cm.release_id == head_q);
    restore_ok  = cm.rat_restore && slots_q[cm.rat_restore_checkpoint].valid;
    flush_off   = flush_slot - head_q;
    restore_off = cm.rat_restore_checkpoint - head_q;
    trunc       = (cm.flush && flush_found) || restore_ok;
    // The older of the two truncation points wins; a younger restore target is freed by the flush anyway
    if (cm.flush && flush_found && (!restore_ok || flush_off <= restore_off))
      trunc_off = flush_off;
    else
      trunc_off = restore_off;

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    slots_d = slots_q;
    err_d   = err_q || (cm.release_valid && !rel_ok);

    if (rel_ok) begin
      slots_d[head_q].valid = 1'b0;
      head_d  = head_q + ckpt_id_t'(1);
      count_d = count_q - ckpt_cnt_t'(1);
    end

    if (trunc) begin
      tail_d = head_q + trunc_off;
      for (int i = 0; i < CHECKPOINT_COUNT; i++) begin
        if (ckpt_id_t'(ckpt_id_t'(i) - head_q) >= trunc_off)
          slots_d[i].valid = 1'b0;
      end
      if (trunc_off == '0) begin
        head_d  = head_q;
        count_d = '0;
      end else begin
        count_d = ckpt_cnt_t'(trunc_off) - ckpt_cnt_t'(rel_ok);
      end
    end

    if (grant) begin
      slots_d[tail_q] = '{valid: 1'b1, rob_idx: cm.alloc_rob_idx};
      tail_d  = tail_q + ckpt_id_t'(1);
      count_d = count_d + ckpt_cnt_t'(1);
    end

`ifdef CKPT_STATS_EN
    stall_d = stall_q;
    if (cm.alloc_req && !alloc_ready && stall_q != 32'hFFFF_FFFF)
      stall_d = stall_q + 32'd1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < CHECKPOINT_COUNT; i++) slots_q[i] <= '0;
`ifdef CKPT_STATS_EN
      stall_q <= '0;
`endif
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
      slots_q <= slots_d;
`ifdef CKPT_STATS_EN
      stall_q <= stall_d;
`endif
    end
  end

  assign cm.alloc_ready   = alloc_ready;
  assign cm.alloc_grant   = grant;
  assign cm.alloc_id      = tail_q;
  assign cm.live_count    = count_q;
  assign cm.empty         = (count_q == '0);
  assign cm.release_error = err_q;
`ifdef CKPT_STATS_EN
  assign cm.stall_cycles  = stall_q;
`endif
endmodule

// File: tb/tb_checkpoint_manager.sv
// tb/tb_checkpoint_manager.sv - directed vector bench for checkpoint_manager
module tb_checkpoint_manager;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  checkpoint_manager_if cm ();
  checkpoint_manager dut (.clk(clk), .rst(rst), .cm(cm));

  typedef struct {
    logic req; logic [6:0] rob; logic rel; logic [2:0] rel_id; logic [6:0] rhead;
    logic fl; logic [6:0] fl_rob; logic rr; logic [2:0] rr_id; logic rip;
    logic e_ready; logic e_grant; logic [2:0] e_id; logic [3:0] e_live; logic e_empty; logic e_err;
  } vec_t;

  vec_t vecs[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic add(input logic req, input logic [6:0] rob, input logic rel, input logic [2:0] rel_id,
                     input logic [6:0] rhead, input logic fl, input logic [6:0] fl_rob, input logic rr,
                     input logic [2:0] rr_id, input logic rip, input logic e_ready, input logic e_grant,
                     input logic [2:0] e_id, input logic [3:0] e_live, input logic e_empty, input logic e_err);
    vec_t v;
    v = '{req, rob, rel, rel_id, rhead, fl, fl_rob, rr, rr_id, rip,
          e_ready, e_grant, e_id, e_live, e_empty, e_err};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic req, input logic [6:0] rob, input logic rel, input logic [2:0] rel_id,
                       input logic fl, input logic [6:0] fl_rob, input logic rr, input logic [2:0] rr_id,
                       input logic rip);
    cm.alloc_req = req; cm.alloc_rob_idx = rob;
    cm.release_valid = rel; cm.release_id = rel_id;
    cm.flush = fl; cm.flush_rob_idx = fl_rob;
    cm.rat_restore = rr; cm.rat_restore_checkpoint = rr_id;
    cm.recovery_in_progress = rip;
  endtask

  task automatic check(input string nm, input logic er, input logic eg, input logic [2:0] eid,
                       input logic [3:0] el, input logic ee, input logic eerr);
    n_vec++;
    if (cm.alloc_ready !== er || cm.alloc_grant !== eg || cm.alloc_id !== eid ||
        cm.live_count !== el || cm.empty !== ee || cm.release_error !== eerr) begin
      n_bad++;
      $display("FAIL %s: got rdy=%b gnt=%b id=%0d live=%0d empty=%b err=%b, want rdy=%b gnt=%b id=%0d live=%0d empty=%b err=%b",
               nm, cm.alloc_ready, cm.alloc_grant, cm.alloc_id, cm.live_count, cm.empty, cm.release_error,
               er, eg, eid, el, ee, eerr);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(input string nm, input logic [3:0] el, input logic [2:0] eid, input logic eerr);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check(nm, el != 4'd8, 1'b0, eid, el, el == 4'd0, eerr);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cm.rob_head = 7'd0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic alloc(input string nm, input logic [6:0] rob, input logic [2:0] eid, input logic [3:0] el);
    drive(1, rob, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check(nm, 1'b1, 1'b1, eid, el, el == 4'd0, 1'b0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int k = 0; k < 8; k++)
      add(1, 7'(2*k), 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3'(k), 4'(k), k == 0, 0);
    add(1, 16, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 8, 0, 0);  // full
    add(1, 16, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 8, 0, 0);  // release while full: no bypass
    add(0,  0, 1, 1, 0, 0,   0, 0, 0, 0, 1, 0, 0, 7, 0, 0);
    add(0,  0, 1, 5, 0, 0,   0, 0, 0, 0, 1, 0, 0, 6, 0, 0);  // out-of-order release
    add(0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 6, 0, 1);
    add(0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 6, 0, 1);
    add(1, 20, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0, 6, 0, 1);  // recovery in progress
    add(1, 20, 0, 0, 0, 1, 127, 0, 0, 0, 0, 0, 0, 6, 0, 1);  // flush hits nothing
    add(1, 20, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 6, 0, 1);  // restore of a freed slot
    add(0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 6, 0, 1);

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cm.rob_head = 7'd0;
    rst = 1'b1;
    #1;
    check("reset", 1'b1, 1'b0, 3'd0, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].req, vecs[i].rob, vecs[i].rel, vecs[i].rel_id, vecs[i].fl, vecs[i].fl_rob,
            vecs[i].rr, vecs[i].rr_id, vecs[i].rip);
      cm.rob_head = vecs[i].rhead;
      #1;
      check($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_grant, vecs[i].e_id,
            vecs[i].e_live, vecs[i].e_empty, vecs[i].e_err);
      tick();
    end
`ifdef CKPT_STATS_EN
    n_vec++;
    if (cm.stall_cycles !== 32'd5) begin
      n_bad++;
      $display("FAIL stall_cycles: got %0d want 5", cm.stall_cycles);
    end
`endif

    // Flush truncation and idempotence
    do_reset();
    for (int k = 0; k < 5; k++) alloc($sformatf("fl_alloc%0d", k), 7'(4*k), 3'(k), 4'(k));
    drive(0, 0, 0, 0, 1, 9, 0, 0, 0);
    #1;
    check("flush_pre", 1'b0, 1'b0, 3'd5, 4'd5, 1'b0, 1'b0);
    tick();
    #1;
    check("flush_again", 1'b0, 1'b0, 3'd3, 4'd3, 1'b0, 1'b0);
    tick();
    check_idle("flush_done", 4'd3, 3'd3, 1'b0);

    // Wrap-around ages, then restores
    do_reset();
    cm.rob_head = 7'd120;
    alloc("wr_a0", 122, 0, 0);
    alloc("wr_a1", 126, 1, 1);
    alloc("wr_a2",   2, 2, 2);
    alloc("wr_a3",   6, 3, 3);
    drive(0, 0, 0, 0, 1, 1, 0, 0, 0);
    tick();
    check_idle("wrap_flush", 4'd2, 3'd2, 1'b0);
    drive(1, 9, 0, 0, 0, 0, 1, 2, 0);
    #1;
    check("restore_freed_pre", 1'b0, 1'b0, 3'd2, 4'd2, 1'b0, 1'b0);
    tick();
    check_idle("restore_freed", 4'd2, 3'd2, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
    tick();
    check_idle("restore_live", 4'd1, 3'd1, 1'b0);

    // Same-cycle release and truncation
    drive(0, 0, 1, 0, 1, 122, 0, 0, 0);
    tick();
    check_idle("rel_flush_head", 4'd0, 3'd0, 1'b0);
    cm.rob_head = 7'd0;
    alloc("sc_a0", 10, 0, 0);
    alloc("sc_a1", 20, 1, 1);
    alloc("sc_a2", 30, 2, 2);
    drive(0, 0, 1, 0, 1, 20, 0, 0, 0);
    tick();
    check_idle("rel_flush_next", 4'd0, 3'd1, 1'b0);
    drive(0, 0, 1, 1, 0, 0, 0, 0, 0);
    tick();
    check_idle("release_empty", 4'd0, 3'd1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
